fmps_collect_multilink: RTL and testbench

- Parametrised successor to the two-link FMPS collection logic.
- Accepts per-FA-cycle status reports from NUM_LINKS links in parallel, all already in the sysClk domain, with no merge mux needed.
- Builds received/enabled node bitmaps and declares the readout complete, or timed out against a runtime-programmable µs limit.
- Sits between the per-link readers and the Mitigation Node / microBlaze CSR.

---
 rtl/fmps_collect_pkg.sv | 33 +++
 rtl/fmps_miss_counters.sv | 45 ++++
 rtl/fmps_collect_multilink.sv | 180 ++++++++++++++++++
 tb/tb_fmps_collect_multilink.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmps_collect_pkg.sv
// Shared types and helpers for the FMPS multi-link collector.
// FSM state encoding, the success status code, the sysClk-to-microsecond
// divide ratio and a node-bitmap popcount.
package fmps_collect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } fmps_state_t;

    localparam logic [1:0] ST_SUCCESS = 2'd0;

    // Widest node bitmap handled by popcount (INDEX_WIDTH up to 8).
    localparam int MAX_NODES = 256;
    localparam int CNT_W     = 9;

    // sysClk cycles per microsecond.
    function automatic int US_DIV(input int rate);
        return rate / 1000000;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_NODES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_NODES; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/fmps_miss_counters.sv
// Per-node 8-bit saturating miss counters with a registered read port.
// Only instantiated when FMPS_MISS_COUNT_EN is defined.
module fmps_miss_counters #(
    parameter int INDEX_WIDTH = 5
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_fa_strobe,
    input  logic [INDEX_WIDTH:0]          i_fmps_count,
    input  logic [(1<<INDEX_WIDTH)-1:0]   i_bitmap_all,
    input  logic                          i_miss_clear,
    input  logic [INDEX_WIDTH-1:0]        i_rd_addr,
    output logic [7:0]                    o_rd_data
);

    localparam int NODES = 1 << INDEX_WIDTH;

    logic [7:0] r_cnt [NODES];
    logic [7:0] r_rd_data;

    // Count a miss for every expected node absent from the outgoing bitmap; clear wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NODES; i++) r_cnt[i] <= '0;
        end else if (i_miss_clear) begin
            for (int i = 0; i < NODES; i++) r_cnt[i] <= '0;
        end else if (i_fa_strobe) begin
            for (int i = 0; i < NODES; i++) begin
                if (((INDEX_WIDTH+1)'(i) < i_fmps_count) && !i_bitmap_all[i] &&
                    (r_cnt[i] != 8'hFF)) begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rd_data <= '0;
        else          r_rd_data <= r_cnt[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fmps_collect_multilink.sv
// FMPS multi-link status collector: merges per-link node reports into
// received/enabled bitmaps and declares each FA-cycle readout complete or
// timed out against a programmable microsecond limit.
// Optional per-node miss counters are built when FMPS_MISS_COUNT_EN is defined.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | after reset, waiting for the first FAstrobe
// ST_ACTIVE  | collecting reports, microsecond timer running
// ST_DONE    | all expected nodes heard, readoutValid high
// ST_TIMEOUT | timer reached timeoutLimit before completion
module fmps_collect_multilink
    import fmps_collect_pkg::*;
#(
    parameter int SYSCLK_RATE = 100000000,
    parameter int NUM_LINKS   = 2,
    parameter int INDEX_WIDTH = 5,
    parameter int TIMER_WIDTH = 8,
    parameter int SEQNO_WIDTH = 3
) (
    input  logic                              sysClk,
    input  logic                              sysResetN,
    input  logic                              FAstrobe,
    input  logic [INDEX_WIDTH:0]              fmpsCount,
    input  logic [TIMER_WIDTH-1:0]            timeoutLimit,
    input  logic [NUM_LINKS-1:0]              linkInhibit,
    input  logic [NUM_LINKS-1:0]              statusValid,
    input  logic [NUM_LINKS*INDEX_WIDTH-1:0]  statusIndex,
    input  logic [NUM_LINKS*2-1:0]            statusCode,
    input  logic [NUM_LINKS-1:0]              statusEnabled,
    output logic [(1<<INDEX_WIDTH)-1:0]       fmpsBitmapAll,
    output logic [(1<<INDEX_WIDTH)-1:0]       fmpsBitmapEnabled,
    output logic [(1<<INDEX_WIDTH)-1:0]       fmpsBitmapAllFASnapshot,
    output logic [(1<<INDEX_WIDTH)-1:0]       fmpsEnableBitmapFASnapshot,
    output logic                              fmpsEnabled,
    output logic                              readoutActive,
    output logic                              readoutValid,
    output logic                              timeoutStrobe,
    output logic                              lateStrobe,
    output logic [TIMER_WIDTH-1:0]            readoutTime,
    output logic [SEQNO_WIDTH-1:0]            seqno
`ifdef FMPS_MISS_COUNT_EN
    ,
    input  logic [INDEX_WIDTH-1:0]            missReadAddr,
    output logic [7:0]                        missReadData,
    input  logic                              missClear
`endif
);

    localparam int NODES = 1 << INDEX_WIDTH;
    localparam int DIV_N = US_DIV(SYSCLK_RATE);
    localparam int DIV_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD  = DIV_W'(DIV_N - 1);
    // Half-period preload rounds the elapsed time to the nearest microsecond.
    localparam logic [DIV_W-1:0] DIV_PRELOAD = (DIV_N >= 2) ? DIV_W'(DIV_N/2 - 1) : '0;

    fmps_state_t              r_state;
    logic [NODES-1:0]         r_bitmap_all;
    logic [NODES-1:0]         r_bitmap_en;
    logic [NODES-1:0]         r_snap_all;
    logic [NODES-1:0]         r_snap_en;
    logic                     r_fmps_enabled;
    logic                     r_timeout_stb;
    logic                     r_late_stb;
    logic [TIMER_WIDTH-1:0]   r_timer;
    logic [TIMER_WIDTH-1:0]   r_readout_time;
    logic [SEQNO_WIDTH-1:0]   r_seqno;
    logic [DIV_W-1:0]         r_div;

    logic [NODES-1:0]         w_hit_all;
    logic [NODES-1:0]         w_hit_en;
    logic                     w_any_acc;
    logic [CNT_W-1:0]         w_cnt_all;
    logic [CNT_W-1:0]         w_cnt_en;
    logic [CNT_W-1:0]         w_count_ext;
    logic                     w_done;
    logic                     w_tmo;

    // Decode accepted reports from all links into per-node hit masks.
    always_comb begin
        w_hit_all = '0;
        w_hit_en  = '0;
        w_any_acc = 1'b0;
        for (int k = 0; k < NUM_LINKS; k++) begin
            if (statusValid[k] && !linkInhibit[k] && (statusCode[k*2 +: 2] == ST_SUCCESS)) begin
                w_any_acc = 1'b1;
                w_hit_all[statusIndex[k*INDEX_WIDTH +: INDEX_WIDTH]] = 1'b1;
                if (statusEnabled[k]) begin
                    w_hit_en[statusIndex[k*INDEX_WIDTH +: INDEX_WIDTH]] = 1'b1;
                end
            end
        end
    end

    assign w_cnt_all   = popcount(MAX_NODES'(r_bitmap_all));
    assign w_cnt_en    = popcount(MAX_NODES'(r_bitmap_en));
    assign w_count_ext = CNT_W'(fmpsCount);
    assign w_done      = (w_cnt_all == w_count_ext);
    assign w_tmo       = (timeoutLimit != '0) && (r_timer >= timeoutLimit);

    // Readout FSM with bitmap accumulation, microsecond timer and result capture.
    always_ff @(posedge sysClk or negedge sysResetN) begin
        if (!sysResetN) begin
            r_state        <= ST_IDLE;
            r_bitmap_all   <= '0;
            r_bitmap_en    <= '0;
            r_snap_all     <= '0;
            r_snap_en      <= '0;
            r_fmps_enabled <= 1'b0;
            r_timeout_stb  <= 1'b0;
            r_late_stb     <= 1'b0;
            r_timer        <= '0;
            r_readout_time <= '0;
            r_seqno        <= '0;
            r_div          <= '0;
        end else begin
            r_timeout_stb <= 1'b0;
            r_late_stb    <= 1'b0;
            if (FAstrobe) begin
                r_state      <= ST_ACTIVE;
                r_snap_all   <= r_bitmap_all;
                r_snap_en    <= r_bitmap_en;
                r_bitmap_all <= '0;
                r_bitmap_en  <= '0;
                r_timer      <= '0;
                r_div        <= DIV_PRELOAD;
            end else if (r_state == ST_ACTIVE) begin
                r_bitmap_all <= r_bitmap_all | w_hit_all;
                r_bitmap_en  <= r_bitmap_en | w_hit_en;
                if (r_div == '0) begin
                    r_div <= DIV_RELOAD;
                    if (r_timer != '1) r_timer <= r_timer + TIMER_WIDTH'(1);
                end else begin
                    r_div <= r_div - DIV_W'(1);
                end
                if (w_done) begin
                    r_state        <= ST_DONE;
                    r_fmps_enabled <= (w_cnt_en == w_count_ext);
                    r_seqno        <= r_seqno + SEQNO_WIDTH'(1);
                    r_readout_time <= r_timer;
                end else if (w_tmo) begin
                    r_state        <= ST_TIMEOUT;
                    r_timeout_stb  <= 1'b1;
                    r_fmps_enabled <= 1'b0;
                    r_readout_time <= r_timer;
                end
            end else begin
                r_late_stb <= w_any_acc;
            end
        end
    end

    assign fmpsBitmapAll              = r_bitmap_all;
    assign fmpsBitmapEnabled          = r_bitmap_en;
    assign fmpsBitmapAllFASnapshot    = r_snap_all;
    assign fmpsEnableBitmapFASnapshot = r_snap_en;
    assign fmpsEnabled                = r_fmps_enabled;
    assign readoutActive              = (r_state == ST_ACTIVE);
    assign readoutValid               = (r_state == ST_DONE);
    assign timeoutStrobe              = r_timeout_stb;
    assign lateStrobe                 = r_late_stb;
    assign readoutTime                = r_readout_time;
    assign seqno                      = r_seqno;

`ifdef FMPS_MISS_COUNT_EN
    fmps_miss_counters #(
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_miss (
        .i_clk        (sysClk),
        .i_rst_n      (sysResetN),
        .i_fa_strobe  (FAstrobe),
        .i_fmps_count (fmpsCount),
        .i_bitmap_all (r_bitmap_all),
        .i_miss_clear (missClear),
        .i_rd_addr    (missReadAddr),
        .o_rd_data    (missReadData)
    );
`endif

endmodule

// File: tb/tb_fmps_collect_multilink.sv
// Self-checking bench for fmps_collect_multilink (miss counters exercised
// when FMPS_MISS_COUNT_EN is defined).
module tb_fmps_collect_multilink;

    localparam int NL   = 2;
    localparam int IW   = 5;
    localparam int NN   = 1 << IW;
    localparam int TW   = 8;
    localparam int SW   = 3;
    localparam int RATE = 100000000;
    localparam int PER  = RATE / 1000000;
    localparam int HALF = PER / 2;

    localparam int S_IDLE = 0, S_ACT = 1, S_DONE = 2, S_TMO = 3;

    logic               sysClk = 1'b0;
    logic               sysResetN;
    logic               FAstrobe;
    logic [IW:0]        fmpsCount;
    logic [TW-1:0]      timeoutLimit;
    logic [NL-1:0]      linkInhibit;
    logic [NL-1:0]      statusValid;
    logic [NL*IW-1:0]   statusIndex;
    logic [NL*2-1:0]    statusCode;
    logic [NL-1:0]      statusEnabled;
    logic [NN-1:0]      fmpsBitmapAll;
    logic [NN-1:0]      fmpsBitmapEnabled;
    logic [NN-1:0]      fmpsBitmapAllFASnapshot;
    logic [NN-1:0]      fmpsEnableBitmapFASnapshot;
    logic               fmpsEnabled;
    logic               readoutActive;
    logic               readoutValid;
    logic               timeoutStrobe;
    logic               lateStrobe;
    logic [TW-1:0]      readoutTime;
    logic [SW-1:0]      seqno;
`ifdef FMPS_MISS_COUNT_EN
    logic [IW-1:0]      missReadAddr;
    logic [7:0]         missReadData;
    logic               missClear;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    int             m_state;
    logic [NN-1:0]  m_all, m_en, m_sall, m_sen;
    logic [SW-1:0]  m_seq;
    logic           m_fen;
    logic [TW-1:0]  m_rtime;
    logic           m_tstb, m_late;
    int             m_cyc;
    int             m_miss [NN];

    always #5 sysClk = ~sysClk;

    fmps_collect_multilink #(
        .SYSCLK_RATE (RATE),
        .NUM_LINKS   (NL),
        .INDEX_WIDTH (IW),
        .TIMER_WIDTH (TW),
        .SEQNO_WIDTH (SW)
    ) dut (
        .sysClk                     (sysClk),
        .sysResetN                  (sysResetN),
        .FAstrobe                   (FAstrobe),
        .fmpsCount                  (fmpsCount),
        .timeoutLimit               (timeoutLimit),
        .linkInhibit                (linkInhibit),
        .statusValid                (statusValid),
        .statusIndex                (statusIndex),
        .statusCode                 (statusCode),
        .statusEnabled              (statusEnabled),
        .fmpsBitmapAll              (fmpsBitmapAll),
        .fmpsBitmapEnabled          (fmpsBitmapEnabled),
        .fmpsBitmapAllFASnapshot    (fmpsBitmapAllFASnapshot),
        .fmpsEnableBitmapFASnapshot (fmpsEnableBitmapFASnapshot),
        .fmpsEnabled                (fmpsEnabled),
        .readoutActive              (readoutActive),
        .readoutValid               (readoutValid),
        .timeoutStrobe              (timeoutStrobe),
        .lateStrobe                 (lateStrobe),
        .readoutTime                (readoutTime),
        .seqno                      (seqno)
`ifdef FMPS_MISS_COUNT_EN
        ,
        .missReadAddr               (missReadAddr),
        .missReadData               (missReadData),
        .missClear                  (missClear)
`endif
    );

    // Elapsed microseconds after c active cycles: first tick after half a
    // microsecond, then one per microsecond, saturating.
    function automatic int timer_us(input int c);
        int t;
        if (c < HALF) return 0;
        t = 1 + (c - HALF) / PER;
        if (t > (1 << TW) - 1) t = (1 << TW) - 1;
        return t;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        m_all = '0; m_en = '0; m_sall = '0; m_sen = '0;
        m_seq = '0; m_fen = 1'b0; m_rtime = '0;
        m_tstb = 1'b0; m_late = 1'b0; m_cyc = 0;
        for (int i = 0; i < NN; i++) m_miss[i] = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic [NN-1:0] acc_all, acc_en;
        logic          any_acc;
        int            t;
        acc_all = '0; acc_en = '0; any_acc = 1'b0;
        for (int k = 0; k < NL; k++) begin
            if (statusValid[k] && !linkInhibit[k] && statusCode[k*2 +: 2] == 2'd0) begin
                any_acc = 1'b1;
                acc_all[statusIndex[k*IW +: IW]] = 1'b1;
                if (statusEnabled[k]) acc_en[statusIndex[k*IW +: IW]] = 1'b1;
            end
        end
        m_tstb = 1'b0;
        m_late = 1'b0;
`ifdef FMPS_MISS_COUNT_EN
        if (missClear) begin
            for (int i = 0; i < NN; i++) m_miss[i] = 0;
        end else if (FAstrobe) begin
            for (int i = 0; i < NN; i++)
                if (i < int'(fmpsCount) && !m_all[i] && m_miss[i] < 255) m_miss[i]++;
        end
`endif
        if (FAstrobe) begin
            m_sall = m_all; m_sen = m_en;
            m_all = '0; m_en = '0;
            m_state = S_ACT; m_cyc = 0;
        end else if (m_state != S_ACT) begin
            m_late = any_acc;
        end else begin
            t = timer_us(m_cyc);
            if ($countones(m_all) == int'(fmpsCount)) begin
                m_state = S_DONE;
                m_fen = ($countones(m_en) == int'(fmpsCount));
                m_seq = m_seq + 1'b1;
                m_rtime = TW'(t);
            end else if (timeoutLimit != 0 && t >= int'(timeoutLimit)) begin
                m_state = S_TMO;
                m_tstb = 1'b1;
                m_fen = 1'b0;
                m_rtime = TW'(t);
            end
            m_all = m_all | acc_all;
            m_en  = m_en | acc_en;
            m_cyc++;
        end
    endtask

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic cycle();
        model_step();
        tick();
    endtask

    task automatic set_rep(input int k, input int idx, input int code, input logic en);
        statusValid[k] = 1'b1;
        statusIndex[k*IW +: IW] = IW'(idx);
        statusCode[k*2 +: 2] = 2'(code);
        statusEnabled[k] = en;
    endtask

    task automatic clr_rep();
        statusValid = '0;
    endtask

    task automatic strobe();
        FAstrobe = 1'b1;
        cycle();
        FAstrobe = 1'b0;
    endtask

    task automatic wait_leave_active(input int budget);
        for (int i = 0; i < budget && m_state == S_ACT; i++) cycle();
    endtask

    task automatic test_reset();
        sysResetN = 1'b0;
        repeat (3) tick();
        checks++; if (fmpsBitmapAll !== '0) begin errors++; $display("FAIL reset_bitmap_all: got %h expected 0", fmpsBitmapAll); end
        checks++; if (fmpsBitmapEnabled !== '0) begin errors++; $display("FAIL reset_bitmap_en: got %h expected 0", fmpsBitmapEnabled); end
        checks++; if (fmpsBitmapAllFASnapshot !== '0 || fmpsEnableBitmapFASnapshot !== '0) begin errors++; $display("FAIL reset_snapshots: got %h/%h expected 0/0", fmpsBitmapAllFASnapshot, fmpsEnableBitmapFASnapshot); end
        checks++; if (readoutActive !== 1'b0 || readoutValid !== 1'b0) begin errors++; $display("FAIL reset_state: got active=%b valid=%b expected 0/0", readoutActive, readoutValid); end
        checks++; if (fmpsEnabled !== 1'b0) begin errors++; $display("FAIL reset_enabled: got %b expected 0", fmpsEnabled); end
        checks++; if (timeoutStrobe !== 1'b0 || lateStrobe !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %b/%b expected 0/0", timeoutStrobe, lateStrobe); end
        checks++; if (readoutTime !== '0) begin errors++; $display("FAIL reset_time: got %0d expected 0", readoutTime); end
        checks++; if (seqno !== '0) begin errors++; $display("FAIL reset_seqno: got %0d expected 0", seqno); end
`ifdef FMPS_MISS_COUNT_EN
        checks++; if (missReadData !== 8'd0) begin errors++; $display("FAIL reset_miss_data: got %0d expected 0", missReadData); end
`endif
        sysResetN = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        fmpsCount = 6'd4; timeoutLimit = '0; linkInhibit = '0;
        strobe();
        checks++; if (readoutActive !== 1'b1) begin errors++; $display("FAIL basic_active: got %b expected 1", readoutActive); end
        for (int i = 0; i < 4; i++) begin
            set_rep(i % 2, i, 0, 1'b1);
            cycle();
            clr_rep();
        end
        wait_leave_active(10);
        checks++; if (readoutValid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", readoutValid); end
        checks++; if (fmpsEnabled !== 1'b1) begin errors++; $display("FAIL basic_enabled: got %b expected 1", fmpsEnabled); end
        checks++; if (seqno !== 3'd1) begin errors++; $display("FAIL basic_seqno: got %0d expected 1", seqno); end
        checks++; if (fmpsBitmapAll !== 32'h0000000F) begin errors++; $display("FAIL basic_bitmap: got %h expected 0000000f", fmpsBitmapAll); end
        checks++; if (readoutTime !== m_rtime) begin errors++; $display("FAIL basic_time: got %0d expected %0d", readoutTime, m_rtime); end
    endtask

    task automatic test_dup();
        fmpsCount = 6'd2; timeoutLimit = '0; linkInhibit = '0;
        strobe();
        set_rep(0, 7, 0, 1'b1);
        set_rep(1, 7, 0, 1'b1);
        cycle();
        clr_rep();
        checks++; if (fmpsBitmapAll !== 32'h00000080) begin errors++; $display("FAIL dup_first: got %h expected 00000080", fmpsBitmapAll); end
        set_rep(0, 8, 0, 1'b0);
        cycle();
        clr_rep();
        checks++; if (readoutActive !== 1'b1) begin errors++; $display("FAIL dup_no_double: got active=%b expected 1", readoutActive); end
        wait_leave_active(10);
        checks++; if (readoutValid !== 1'b1) begin errors++; $display("FAIL dup_valid: got %b expected 1", readoutValid); end
        checks++; if (fmpsBitmapAll !== 32'h00000180) begin errors++; $display("FAIL dup_bitmap: got %h expected 00000180", fmpsBitmapAll); end
        checks++; if (fmpsBitmapEnabled !== 32'h00000080) begin errors++; $display("FAIL dup_bitmap_en: got %h expected 00000080", fmpsBitmapEnabled); end
        checks++; if (fmpsEnabled !== 1'b0) begin errors++; $display("FAIL dup_enabled: got %b expected 0", fmpsEnabled); end
        checks++; if (seqno !== 3'd2) begin errors++; $display("FAIL dup_seqno: got %0d expected 2", seqno); end
    endtask

    task automatic test_timeout();
        int n_stb, d_cyc, exp_cyc;
        n_stb = 0; d_cyc = -1; exp_cyc = -2;
        fmpsCount = 6'd3; timeoutLimit = 8'd10; linkInhibit = '0;
        strobe();
        set_rep(0, 0, 0, 1'b1);
        set_rep(1, 1, 0, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            cycle();
            clr_rep();
            if (timeoutStrobe) begin n_stb++; d_cyc = i; end
            if (m_tstb) exp_cyc = i;
            if (m_state != S_ACT && i > exp_cyc + 3) break;
        end
        checks++; if (n_stb !== 1) begin errors++; $display("FAIL tmo_pulses: got %0d expected 1", n_stb); end
        checks++; if (d_cyc !== exp_cyc) begin errors++; $display("FAIL tmo_cycle: got %0d expected %0d", d_cyc, exp_cyc); end
        checks++; if (d_cyc < 930 || d_cyc > 970) begin errors++; $display("FAIL tmo_window: got %0d expected 930..970", d_cyc); end
        checks++; if (readoutTime !== 8'd10) begin errors++; $display("FAIL tmo_time: got %0d expected 10", readoutTime); end
        checks++; if (fmpsEnabled !== 1'b0) begin errors++; $display("FAIL tmo_enabled: got %b expected 0", fmpsEnabled); end
        checks++; if (readoutActive !== 1'b0 || readoutValid !== 1'b0) begin errors++; $display("FAIL tmo_state: got active=%b valid=%b expected 0/0", readoutActive, readoutValid); end
        checks++; if (seqno !== 3'd2) begin errors++; $display("FAIL tmo_seqno: got %0d expected 2", seqno); end
    endtask

    task automatic test_inhibit_late();
        fmpsCount = 6'd2; timeoutLimit = 8'd3; linkInhibit = 2'b10;
        strobe();
        for (int i = 0; i < 5; i++) begin
            set_rep(1, 4 + i, 0, 1'b1);
            cycle();
            clr_rep();
        end
        checks++; if (fmpsBitmapAll !== '0) begin errors++; $display("FAIL inh_bitmap: got %h expected 0", fmpsBitmapAll); end
        wait_leave_active(600);
        checks++; if (readoutActive !== 1'b0 || readoutValid !== 1'b0) begin errors++; $display("FAIL inh_timeout: got active=%b valid=%b expected 0/0", readoutActive, readoutValid); end
        set_rep(0, 5, 0, 1'b1);
        cycle();
        clr_rep();
        checks++; if (lateStrobe !== 1'b1) begin errors++; $display("FAIL late_pulse: got %b expected 1", lateStrobe); end
        checks++; if (fmpsBitmapAll !== '0) begin errors++; $display("FAIL late_bitmap: got %h expected 0", fmpsBitmapAll); end
        set_rep(1, 6, 0, 1'b1);
        cycle();
        clr_rep();
        checks++; if (lateStrobe !== 1'b0) begin errors++; $display("FAIL late_inhibited: got %b expected 0", lateStrobe); end
    endtask

    task automatic test_coincident();
        fmpsCount = 6'd4; timeoutLimit = '0; linkInhibit = '0;
        strobe();
        for (int i = 0; i < 2; i++) begin
            set_rep(0, 2*i, 0, 1'b1);
            set_rep(1, 2*i + 1, 0, 1'b1);
            cycle();
            clr_rep();
        end
        wait_leave_active(10);
        FAstrobe = 1'b1;
        set_rep(0, 9, 0, 1'b1);
        cycle();
        FAstrobe = 1'b0;
        clr_rep();
        checks++; if (fmpsBitmapAllFASnapshot !== 32'h0000000F) begin errors++; $display("FAIL coin_snap_all: got %h expected 0000000f", fmpsBitmapAllFASnapshot); end
        checks++; if (fmpsEnableBitmapFASnapshot !== 32'h0000000F) begin errors++; $display("FAIL coin_snap_en: got %h expected 0000000f", fmpsEnableBitmapFASnapshot); end
        checks++; if (fmpsBitmapAll !== '0) begin errors++; $display("FAIL coin_cleared: got %h expected 0", fmpsBitmapAll); end
        cycle();
        checks++; if (fmpsBitmapAll !== '0 || readoutActive !== 1'b1) begin errors++; $display("FAIL coin_dropped: got %h active=%b expected 0 active=1", fmpsBitmapAll, readoutActive); end
    endtask

    task automatic test_reset_mid();
        set_rep(0, 2, 0, 1'b1);
        cycle();
        clr_rep();
        #2;
        sysResetN = 1'b0;
        #1;
        checks++; if (readoutActive !== 1'b0) begin errors++; $display("FAIL rstmid_active: got %b expected 0", readoutActive); end
        checks++; if (fmpsBitmapAll !== '0 || fmpsBitmapAllFASnapshot !== '0) begin errors++; $display("FAIL rstmid_bitmaps: got %h/%h expected 0/0", fmpsBitmapAll, fmpsBitmapAllFASnapshot); end
        checks++; if (seqno !== '0 || readoutTime !== '0) begin errors++; $display("FAIL rstmid_regs: got seq=%0d time=%0d expected 0/0", seqno, readoutTime); end
        tick();
        checks++; if (timeoutStrobe !== 1'b0 || lateStrobe !== 1'b0) begin errors++; $display("FAIL rstmid_strobes: got %b/%b expected 0/0", timeoutStrobe, lateStrobe); end
        sysResetN = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        int extra;
        for (int trial = 0; trial < 25; trial++) begin
            fmpsCount = 6'($urandom_range(6, 1));
            timeoutLimit = '0;
            linkInhibit = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
            strobe();
            checks++; if (fmpsBitmapAllFASnapshot !== m_sall) begin errors++; $display("FAIL rnd_snap: got %h expected %h", fmpsBitmapAllFASnapshot, m_sall); end
            extra = 0;
            for (int c = 0; c < 60; c++) begin
                for (int k = 0; k < NL; k++) begin
                    if ($urandom_range(1) == 1)
                        set_rep(k, $urandom_range(7),
                                ($urandom_range(3) == 0) ? $urandom_range(3, 1) : 0,
                                $urandom_range(4) != 0);
                end
                cycle();
                clr_rep();
                checks++; if (fmpsBitmapAll !== m_all) begin errors++; $display("FAIL rnd_bitmap_all: got %h expected %h", fmpsBitmapAll, m_all); end
                checks++; if (fmpsBitmapEnabled !== m_en) begin errors++; $display("FAIL rnd_bitmap_en: got %h expected %h", fmpsBitmapEnabled, m_en); end
                checks++; if (readoutValid !== (m_state == S_DONE)) begin errors++; $display("FAIL rnd_valid: got %b expected %b", readoutValid, m_state == S_DONE); end
                checks++; if (lateStrobe !== m_late) begin errors++; $display("FAIL rnd_late: got %b expected %b", lateStrobe, m_late); end
                if (m_state != S_ACT) extra++;
                if (extra > 4) break;
            end
            checks++; if (seqno !== m_seq) begin errors++; $display("FAIL rnd_seqno: got %0d expected %0d", seqno, m_seq); end
            checks++; if (fmpsEnabled !== m_fen) begin errors++; $display("FAIL rnd_enabled: got %b expected %b", fmpsEnabled, m_fen); end
            checks++; if (readoutTime !== m_rtime) begin errors++; $display("FAIL rnd_time: got %0d expected %0d", readoutTime, m_rtime); end
        end
    endtask

`ifdef FMPS_MISS_COUNT_EN
    task automatic test_miss();
        int exp_v;
        fmpsCount = 6'd4; timeoutLimit = '0; linkInhibit = '0;
        for (int i = 0; i < 301; i++) begin
            missClear = (i == 0);
            strobe();
            missClear = 1'b0;
            set_rep(0, 0, 0, 1'b1);
            set_rep(1, 1, 0, 1'b1);
            cycle();
            clr_rep();
            set_rep(0, 3, 0, 1'b1);
            cycle();
            clr_rep();
        end
        for (int a = 0; a < 8; a++) begin
            missReadAddr = IW'(a);
            cycle();
            exp_v = (a == 2) ? 255 : 0;
            checks++; if (int'(missReadData) !== exp_v || exp_v !== m_miss[a]) begin errors++; $display("FAIL miss_count[%0d]: got %0d expected %0d (model %0d)", a, missReadData, exp_v, m_miss[a]); end
        end
        missClear = 1'b1;
        cycle();
        missClear = 1'b0;
        for (int a = 0; a < 4; a++) begin
            missReadAddr = IW'(a);
            cycle();
            checks++; if (missReadData !== 8'd0) begin errors++; $display("FAIL miss_clear[%0d]: got %0d expected 0", a, missReadData); end
        end
    endtask
`endif

    initial begin
        FAstrobe = 1'b0; fmpsCount = '0; timeoutLimit = '0; linkInhibit = '0;
        statusValid = '0; statusIndex = '0; statusCode = '0; statusEnabled = '0;
`ifdef FMPS_MISS_COUNT_EN
        missReadAddr = '0; missClear = 1'b0;
`endif
        model_reset();
        test_reset();
        test_basic();
        test_dup();
        test_timeout();
        test_inhibit_late();
        test_coincident();
        test_reset_mid();
        test_random();
`ifdef FMPS_MISS_COUNT_EN
        test_miss();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected completion within time limit");
        $fatal(1, "simulation time limit reached");
    end

endmodule
